// File: rtl/button_pkg.sv
// Shared definitions for pushbutton input blocks: FSM encoding and default
// timing constants for the 16 MHz board clock.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int CLK_HZ                  = 16_000_000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;  // 10 ms
    localparam int LONG_CYCLES_DEFAULT     = CLK_HZ;        // 1 s

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset loads a
// caller-chosen idle level so no spurious edge is seen after reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta_reg <= RESET_VALUE;
            sync_reg <= RESET_VALUE;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/button_reader.sv
// Pushbutton front end: synchronize, debounce, and emit press / release /
// long-press pulses plus a clean pressed level. All outputs registered.
module button_reader
    import button_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic PRESSED,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG_PRESS
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [DW-1:0] DCNT_ONE  = DW'(1);

    logic btn_sync;
    logic b;

    btn_state_t    state_reg, state_next;
    logic [DW-1:0] dcnt_reg, dcnt_next;
    logic [HW-1:0] hcnt_reg, hcnt_next;
    logic          pressed_reg, pressed_next;
    logic          press_reg, press_next;
    logic          release_reg, release_next;
    logic          long_reg, long_next;

    sync_2ff #(
        .RESET_VALUE (ACTIVE_LOW)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (BTN),
        .q   (btn_sync)
    );

    // Normalized so that 1 always means "pressed".
    assign b = btn_sync ^ ACTIVE_LOW;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            dcnt_reg    <= '0;
            hcnt_reg    <= '0;
            pressed_reg <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            long_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dcnt_reg    <= dcnt_next;
            hcnt_reg    <= hcnt_next;
            pressed_reg <= pressed_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            long_reg    <= long_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dcnt_next    = dcnt_reg;
        hcnt_next    = hcnt_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (b) begin
                    state_next = PRESS_WAIT;
                    dcnt_next  = DCNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!b) begin
                    state_next = IDLE;
                    dcnt_next  = '0;
                end else if (dcnt_reg == DCNT_LAST) begin
                    state_next = HELD;
                    dcnt_next  = '0;
                    hcnt_next  = '0;
                    press_next = 1'b1;
                end else begin
                    dcnt_next = dcnt_reg + 1'b1;
                end
            end
            HELD: begin
                // Saturating hold count; the pulse fires only on the step
                // into the terminal value, so it cannot repeat within a press.
                if (hcnt_reg < HCNT_LAST) begin
                    hcnt_next = hcnt_reg + 1'b1;
                    long_next = (hcnt_reg == HCNT_LAST - 1'b1);
                end
                if (!b) begin
                    state_next = RELEASE_WAIT;
                    dcnt_next  = DCNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (b) begin
                    state_next = HELD;
                    dcnt_next  = '0;
                end else if (dcnt_reg == DCNT_LAST) begin
                    state_next   = IDLE;
                    dcnt_next    = '0;
                    release_next = 1'b1;
                end else begin
                    dcnt_next = dcnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                dcnt_next  = '0;
                hcnt_next  = '0;
            end
        endcase
        pressed_next = (state_next == HELD) || (state_next == RELEASE_WAIT);
    end

    assign PRESSED    = pressed_reg;
    assign PRESS      = press_reg;
    assign RELEASE    = release_reg;
    assign LONG_PRESS = long_reg;

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: run-length behavioural model checked every cycle
// against two instances (active-low and active-high pins), plus directed scenarios.
module tb_button_reader;

    localparam int D  = 4;
    localparam int LC = 20;

    logic CLK = 1'b0;
    logic RST;
    logic BTN;
    logic btn_inv;
    logic pressed1, press1, release1, long1;
    logic pressed0, press0, release0, long0;

    always #5 CLK = ~CLK;
    assign btn_inv = ~BTN;

    button_reader #(.ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(LC)) dut1 (
        .CLK(CLK), .RST(RST), .BTN(BTN),
        .PRESSED(pressed1), .PRESS(press1), .RELEASE(release1), .LONG_PRESS(long1)
    );

    button_reader #(.ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(LC)) dut0 (
        .CLK(CLK), .RST(RST), .BTN(btn_inv),
        .PRESSED(pressed0), .PRESS(press0), .RELEASE(release0), .LONG_PRESS(long0)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Model: a level is accepted after D consecutive opposing samples of the
    // synchronized pin; hold time counts cycles spent pressed with no
    // pending release, and the long pulse fires when it reaches LC-1.
    bit m_s1, m_s2, m_pressed, m_fired;
    int m_run, m_hold;
    bit e_pressed, e_press, e_rel, e_long;

    always @(posedge CLK) begin
        bit b;
        cyc++;
        if (RST) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_pressed = 1'b0; m_fired = 1'b0; m_run = 0; m_hold = 0;
            e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
        end else begin
            b = ~m_s2;
            e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
            if (m_pressed && m_run == 0 && m_hold < LC - 1) begin
                m_hold++;
                if (m_hold == LC - 1 && !m_fired) begin
                    e_long = 1'b1;
                    m_fired = 1'b1;
                end
            end
            if (b != m_pressed) m_run++;
            else m_run = 0;
            if (m_run == D) begin
                m_pressed = b;
                m_run = 0;
                if (b) begin
                    e_press = 1'b1; m_hold = 0; m_fired = 1'b0;
                end else begin
                    e_rel = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = BTN;
        end
        e_pressed = m_pressed;
    end

    always @(negedge CLK) begin
        if (check_en) begin
            check4("dut1_outputs", {pressed1, press1, release1, long1}, {e_pressed, e_press, e_rel, e_long});
            check4("dut0_outputs", {pressed0, press0, release0, long0}, {e_pressed, e_press, e_rel, e_long});
        end
    end

    // Event log from the active-low instance: 0=press 1=release 2=long.
    int cnt[3];
    int at[3];
    int press0_at = -1;
    bit pressed_at_rel;

    always @(negedge CLK) begin
        if (check_en) begin
            if (press1)   begin cnt[0]++; at[0] = cyc; end
            if (release1) begin cnt[1]++; at[1] = cyc; pressed_at_rel = pressed1; end
            if (long1)    begin cnt[2]++; at[2] = cyc; end
            if (press0)   press0_at = cyc;
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_evt(input int which, input int budget, output int seen);
        int base;
        base = cnt[which];
        seen = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (cnt[which] > base) begin
                seen = at[which];
                break;
            end
        end
    endtask

    initial begin
        int m, seen, seen2, bp, br, bl;
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        at[0] = -1; at[1] = -1; at[2] = -1;
        pressed_at_rel = 1'b1;
        RST = 1'b1;
        BTN = 1'b1;

        // Reset and idle
        tick();
        check_en = 1'b1;
        check4("reset_outputs", {pressed1, press1, release1, long1}, 4'b0000);
        tick(); tick();
        RST = 1'b0;
        repeat (50) tick();
        check_int("idle_no_press", cnt[0], 0);
        check4("idle_outputs", {pressed1, press1, release1, long1}, 4'b0000);
        $display("scenario reset_idle presses=%0d", cnt[0]);

        // Clean press and long press
        bl = cnt[2];
        m = cyc;
        BTN = 1'b0;
        wait_evt(0, 20, seen);
        check_int("press_latency", seen - m, 6);
        check_int("polarity_press_cycle", press0_at, seen);
        check_int("pressed_after_press", int'(pressed1), 1);
        wait_evt(2, 40, seen2);
        check_int("long_after_press", seen2 - seen, 19);
        repeat (100) tick();
        check_int("single_long", cnt[2] - bl, 1);
        $display("scenario clean_press press_at=%0d long_at=%0d", seen, seen2);

        // Release glitch while held
        bp = cnt[0]; br = cnt[1];
        BTN = 1'b1;
        repeat (3) tick();
        BTN = 1'b0;
        repeat (20) tick();
        check_int("glitch_no_release", cnt[1] - br, 0);
        check_int("glitch_no_press", cnt[0] - bp, 0);
        check_int("glitch_still_pressed", int'(pressed1), 1);
        $display("scenario release_glitch pressed=%0b", pressed1);

        // Clean release
        m = cyc;
        BTN = 1'b1;
        wait_evt(1, 20, seen);
        check_int("release_latency", seen - m, 6);
        check_int("pressed_with_release", int'(pressed_at_rel), 0);
        repeat (10) tick();
        $display("scenario clean_release release_at=%0d", seen);

        // Press bounce
        bp = cnt[0];
        BTN = 1'b0; repeat (3) tick();
        BTN = 1'b1; repeat (2) tick();
        BTN = 1'b0; repeat (2) tick();
        BTN = 1'b1; repeat (20) tick();
        check_int("bounce_no_press", cnt[0] - bp, 0);
        check_int("bounce_not_pressed", int'(pressed1), 0);
        $display("scenario bounce presses=%0d", cnt[0] - bp);

        // Short press
        bp = cnt[0]; br = cnt[1]; bl = cnt[2];
        BTN = 1'b0;
        wait_evt(0, 20, seen);
        repeat (10) tick();
        BTN = 1'b1;
        wait_evt(1, 20, seen2);
        repeat (30) tick();
        check_int("short_press_count", cnt[0] - bp, 1);
        check_int("short_release_count", cnt[1] - br, 1);
        check_int("short_no_long", cnt[2] - bl, 0);
        $display("scenario short_press press_at=%0d release_at=%0d", seen, seen2);

        // Reset mid-press
        br = cnt[1];
        BTN = 1'b0;
        wait_evt(0, 20, seen);
        repeat (3) tick();
        RST = 1'b1;
        tick();
        check4("midreset_outputs", {pressed1, press1, release1, long1}, 4'b0000);
        RST = 1'b0;
        m = cyc;
        wait_evt(0, 20, seen2);
        check_int("repress_latency", seen2 - m, 6);
        check_int("midreset_no_release", cnt[1] - br, 0);
        BTN = 1'b1;
        wait_evt(1, 20, seen);
        repeat (5) tick();
        $display("scenario reset_mid_press repress_at=%0d", seen2);

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Input-side counterpart to the board's LED output drivers: samples a raw pushbutton pin on the TinyFPGA BX, synchronizes and debounces it, and reports clean press/release/long-press events to user logic.
- Runs in the 16 MHz CLK domain.
- Provides the front end for all future user-input sample designs (mode select, LED pattern step, etc.).

Parameters:
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (internal pull-up); 0 = pin reads 1 when pressed.
- DEBOUNCE_CYCLES, 160000, consecutive stable samples required to accept a level change (10 ms at 16 MHz); must be >= 2.
- LONG_CYCLES, 16000000, pressed duration (cycles in HELD) that triggers LONG_PRESS (1 s at 16 MHz); must be >= 2.

Ports:
- CLK  input  1  16 MHz system clock.
- RST  input  1  synchronous, active-high reset.
- BTN  input  1  raw asynchronous button pin.
- PRESSED  output  1  debounced level; 1 while the button is accepted as pressed.
- PRESS  output  1  one-cycle pulse when a press is accepted.
- RELEASE  output  1  one-cycle pulse when a release is accepted.
- LONG_PRESS  output  1  one-cycle pulse, once per press, when hold time reaches LONG_CYCLES.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST). All outputs are registered.
- Reset values:
  - Synchronizer flops load the released pin level (1 if ACTIVE_LOW, else 0).
  - FSM = IDLE; all counters 0.
  - PRESSED = PRESS = RELEASE = LONG_PRESS = 0.
- Synchronizer: two flops on BTN. The normalized signal b = sync2 XOR ACTIVE_LOW, so 1 = pressed.
- Debounce counter dcnt: width clog2(DEBOUNCE_CYCLES). Hold counter hcnt: width clog2(LONG_CYCLES), saturating.
- FSM states and transitions:
  - IDLE: if b=1 -> PRESS_WAIT with dcnt=1; otherwise stay.
  - PRESS_WAIT:
    - b=0 -> IDLE, dcnt=0 (bounce rejected, no pulse).
    - b=1 and dcnt==DEBOUNCE_CYCLES-1 -> HELD; PRESS=1 and PRESSED=1 next cycle; hcnt=0.
    - Otherwise dcnt+1.
  - HELD:
    - If hcnt < LONG_CYCLES-1, increment hcnt.
    - On the edge where hcnt becomes LONG_CYCLES-1, LONG_PRESS=1 for one cycle. hcnt then saturates; no repeat.
    - b=0 -> RELEASE_WAIT with dcnt=1; hcnt frozen.
  - RELEASE_WAIT:
    - b=1 -> HELD, dcnt=0. No PRESS pulse; hcnt resumes from its frozen value and LONG_PRESS stays fired if already fired.
    - b=0 and dcnt==DEBOUNCE_CYCLES-1 -> IDLE; RELEASE=1 and PRESSED=0 next cycle.
    - Otherwise dcnt+1.
- PRESSED is 1 in HELD and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
- Latency: with BTN held stable from before clock edge k, PRESS is high in the cycle after edge k+DEBOUNCE_CYCLES+1. Release latency is identical.
- Pulses are mutually exclusive in any cycle, except that PRESS and LONG_PRESS cannot coincide because LONG_CYCLES >= 2.
- A press shorter than DEBOUNCE_CYCLES samples produces no events.
- A release glitch shorter than DEBOUNCE_CYCLES produces no events and keeps PRESSED=1.
- RST asserted in any state: return to reset values on the next edge, with no RELEASE pulse even if PRESSED was 1. After reset, a button still held is re-debounced and produces a fresh PRESS.

Decomposition:
- Shared package/header button_pkg:
  - FSM state encodings IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3.
  - Default cycle constants derived from 16 MHz (10 ms, 1 s).
- One sub-module, sync_2ff: a two-flop synchronizer with a reset-value parameter, reused by later input blocks.

Test Plan (ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, LONG_CYCLES=20 unless noted):
- Reset and idle: hold BTN=1 and pulse RST -> all outputs 0 for 50 cycles, state IDLE.
- Clean press: BTN 1->0 before edge k and held -> PRESS single pulse in the cycle after edge k+5, PRESSED=1 from that cycle; LONG_PRESS single pulse 19 edges after PRESS; no second LONG_PRESS over the next 100 cycles.
- Bounce rejection: BTN low 3 cycles / high 2 / low 2 / high -> no PRESS, PRESSED stays 0. Release glitch of 3 cycles while HELD -> PRESSED stays 1, no RELEASE, no PRESS.
- Clean release: after HELD, BTN 0->1 held -> RELEASE single pulse 6 edges later, PRESSED=0 in the same cycle as the RELEASE pulse.
- Short press: press held 10 cycles past PRESS, then released -> PRESS and RELEASE each once, no LONG_PRESS.
- Reset mid-press: RST while PRESSED=1 with BTN still low -> outputs 0 after the reset edge with no RELEASE pulse; after RST deasserts, PRESS occurs again DEBOUNCE_CYCLES+2 edges later.
- Polarity: repeat the clean-press scenario with ACTIVE_LOW=0 and inverted BTN stimulus -> identical event timing.
